// File: rtl/s_regfile_rsv.sv
// Scalar register file with per-register reservation bits, NWR write-back
// ports and same-cycle write-to-read bypass on the j/k/i operand ports.
// Issue reserves a destination register; write-back delivers the result and
// releases the reservation. Register 0 also drives the branch-condition flags.
//
// Port timing: reads, busy outputs and S0 flags are combinational.
// o_rsv_err and o_busy_cnt are registered and reflect the previous edge.
module s_regfile_rsv #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int LOGDEPTH = 3,
  parameter int NWR      = 2,
  parameter int CONST_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LOGDEPTH-1:0]     i_j_addr,
  input  logic [LOGDEPTH-1:0]     i_k_addr,
  input  logic [LOGDEPTH-1:0]     i_i_addr,
  input  logic [LOGDEPTH-1:0]     i_ex_addr,
  output logic [WIDTH-1:0]        o_j_data,
  output logic [WIDTH-1:0]        o_k_data,
  output logic [WIDTH-1:0]        o_i_data,
  output logic [WIDTH-1:0]        o_ex_data,
  output logic                    o_j_busy,
  output logic                    o_k_busy,
  output logic                    o_i_busy,
  input  logic [NWR-1:0]          i_wr_en,
  input  logic [NWR*LOGDEPTH-1:0] i_wr_addr,
  input  logic [NWR*WIDTH-1:0]    i_wr_data,
  input  logic                    i_rsv_en,
  input  logic [LOGDEPTH-1:0]     i_rsv_addr,
  output logic                    o_rsv_err,
  output logic [LOGDEPTH:0]       o_busy_cnt,
  output logic                    o_s0_pos,
  output logic                    o_s0_neg,
  output logic                    o_s0_zero,
  output logic                    o_s0_nzero
);

  // k operand reading register 0 returns the sign-bit constant
  localparam logic [WIDTH-1:0] K_CONST = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]    regs     [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    busy_nxt;
  logic [DEPTH-1:0]    wr_hit;
  logic [WIDTH-1:0]    wr_val   [DEPTH];
  logic                rsv_err_nxt;
  logic [LOGDEPTH:0]   cnt_nxt;
  logic [LOGDEPTH-1:0] rd_addr  [3];
  logic [WIDTH-1:0]    rd_data  [3];
  logic                rd_busy  [3];
  logic [WIDTH-1:0]    ex_data;

  // Per-register write decode; later (higher) ports override earlier ones.
  // Out-of-range addresses never match any register index, so they drop out.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (i_wr_en[p] &&
            ({1'b0, i_wr_addr[p*LOGDEPTH +: LOGDEPTH]} == (LOGDEPTH+1)'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = i_wr_data[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next busy vector (reserve beats write-back release), reserve-conflict
  // detection and the population count presented after the edge.
  always_comb begin
    busy_nxt    = busy;
    rsv_err_nxt = 1'b0;
    cnt_nxt     = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (wr_hit[r]) begin
        busy_nxt[r] = 1'b0;
      end
      if (i_rsv_en && ({1'b0, i_rsv_addr} == (LOGDEPTH+1)'(r))) begin
        busy_nxt[r] = 1'b1;
        if (busy[r] && !wr_hit[r]) begin
          rsv_err_nxt = 1'b1;
        end
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt = cnt_nxt + (LOGDEPTH+1)'(busy_nxt[r]);
    end
  end

  // Operand reads: bypass first, then constant substitution on j/k address 0,
  // then stored data. Index 0 = j, 1 = k, 2 = i (never substituted).
  always_comb begin
    rd_addr[0] = i_j_addr;
    rd_addr[1] = i_k_addr;
    rd_addr[2] = i_i_addr;
    for (int q = 0; q < 3; q++) begin
      rd_data[q] = '0;
      rd_busy[q] = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        if ({1'b0, rd_addr[q]} == (LOGDEPTH+1)'(r)) begin
          rd_data[q] = wr_hit[r] ? wr_val[r] : regs[r];
          rd_busy[q] = busy[r] & ~wr_hit[r];
        end
      end
      if ((CONST_EN != 0) && (q != 2) && (rd_addr[q] == '0)) begin
        rd_busy[q] = 1'b0;
        if (!wr_hit[0]) begin
          rd_data[q] = (q == 0) ? '0 : K_CONST;
        end
      end
    end
  end

  // Exchange-package read: stored contents only, no bypass
  always_comb begin
    ex_data = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if ({1'b0, i_ex_addr} == (LOGDEPTH+1)'(r)) begin
        ex_data = regs[r];
      end
    end
  end

  // State update; reset discards in-flight writes and reservations
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy       <= '0;
      o_rsv_err  <= 1'b0;
      o_busy_cnt <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      busy       <= busy_nxt;
      o_rsv_err  <= rsv_err_nxt;
      o_busy_cnt <= cnt_nxt;
    end
  end

  assign o_j_data  = rd_data[0];
  assign o_k_data  = rd_data[1];
  assign o_i_data  = rd_data[2];
  assign o_j_busy  = rd_busy[0];
  assign o_k_busy  = rd_busy[1];
  assign o_i_busy  = rd_busy[2];
  assign o_ex_data = ex_data;

  // Branch-condition flags from stored register 0
  assign o_s0_neg   = regs[0][WIDTH-1];
  assign o_s0_pos   = ~regs[0][WIDTH-1];
  assign o_s0_zero  = (regs[0] == '0);
  assign o_s0_nzero = (regs[0] != '0);

endmodule
